// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: result in cycle XLEN/BITS_PER_CYCLE+1 after accept, cycle 1 for div corner cases.
// Backpressure: ready_o low from accept until the result cycle ends; the result pulse itself cannot be stalled.
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic                neg_q, neg_d;
    logic                fast_q, fast_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Multiply keeps {partial_hi, remaining multiplier}; divide keeps {remainder, dividend/quotient}.
    logic [XLEN+BITS_PER_CYCLE-1:0] mul_pp, mul_sum;
    logic [2*XLEN-1:0]              mul_next, div_next;
    logic [XLEN:0]                  div_trial;
    logic [XLEN-1:0]                div_rem, div_quo;

    always_comb begin
        mul_pp   = {{BITS_PER_CYCLE{1'b0}}, opb_q} * {{XLEN{1'b0}}, acc_q[BITS_PER_CYCLE-1:0]};
        mul_sum  = {{BITS_PER_CYCLE{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mul_pp;
        mul_next = {mul_sum, acc_q[XLEN-1:BITS_PER_CYCLE]};

        div_rem   = acc_q[2*XLEN-1:XLEN];
        div_quo   = acc_q[XLEN-1:0];
        div_trial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            div_trial = {div_rem, div_quo[XLEN-1]};
            div_quo   = {div_quo[XLEN-2:0], 1'b0};
            if (div_trial >= {1'b0, opb_q}) begin
                div_trial  = div_trial - {1'b0, opb_q};
                div_quo[0] = 1'b1;
            end
            div_rem = div_trial[XLEN-1:0];
        end
        div_next = {div_rem, div_quo};
    end

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, final_res;

    always_comb begin
        prod_s = neg_q ? -acc_q : acc_q;
        quo_s  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_s  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:         final_res = prod_s[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         final_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101: final_res = quo_s;
            default:        final_res = rem_s;
        endcase
        if (fast_q) begin
            final_res = acc_q[XLEN-1:0];
        end
    end

    logic            a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        a_sgn    = funct3_i[2] ? !funct3_i[0] : (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10);
        b_sgn    = funct3_i[2] ? !funct3_i[0] : (funct3_i[1:0] == 2'b01);
        a_neg    = a_sgn & a_i[XLEN-1];
        b_neg    = b_sgn & b_i[XLEN-1];
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;
        div_zero = funct3_i[2] && (b_i == '0);
        div_ovf  = funct3_i[2] && !funct3_i[0] && (a_i == MOST_NEG) && (b_i == ALL_ONES);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        fast_d   = fast_q;
        result_d = result_q;
        ready_o  = (state_q == IDLE);
        valid_o  = 1'b0;
        result_o = result_q;
        case (state_q)
            IDLE: begin
                if (valid_i && !flush_i) begin
                    op_d    = funct3_i;
                    opb_d   = b_mag;
                    acc_d   = {{XLEN{1'b0}}, a_mag};
                    cnt_d   = CW'(N);
                    fast_d  = 1'b0;
                    // Remainder follows the dividend; everything else follows the operand sign product.
                    neg_d   = (funct3_i[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);
                    state_d = CALC;
                    if (div_zero) begin
                        fast_d  = 1'b1;
                        neg_d   = 1'b0;
                        acc_d   = {{XLEN{1'b0}}, funct3_i[1] ? a_i : ALL_ONES};
                        state_d = DONE;
                    end else if (div_ovf) begin
                        fast_d  = 1'b1;
                        neg_d   = 1'b0;
                        acc_d   = {{XLEN{1'b0}}, funct3_i[1] ? {XLEN{1'b0}} : MOST_NEG};
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush_i) begin
                    valid_o  = 1'b1;
                    result_o = final_res;
                    result_d = final_res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            fast_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            fast_q   <= fast_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised bench for muldiv_unit: scoreboard of expected results/cycles against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, flush_i, ready_o, valid_o;
    logic [2:0]  funct3_i;
    logic [31:0] a_i, b_i, result_o;

    logic        v4, rdy4, vo4;
    logic [2:0]  f4;
    logic [31:0] a4, b4, r4;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .funct3_i(funct3_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
        .valid_o(valid_o), .result_o(result_o));

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(v4), .ready_o(rdy4),
        .funct3_i(f4), .a_i(a4), .b_i(b4), .flush_i(1'b0),
        .valid_o(vo4), .result_o(r4));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] exp_res_q[$];
    int          exp_cyc_q[$];
    int          busy_until = -1;
    logic [31:0] last_res = '0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] pu;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        pu = '0;
        r  = '0;
        case (f)
            3'd0: begin pu = sa * sb; r = pu[31:0]; end
            3'd1: begin pu = sa * sb; r = pu[63:32]; end
            3'd2: begin pu = sa * ub; r = pu[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
            3'd4: begin
                if (b == 0) r = '1;
                else if (a == MIN && b == '1) r = MIN;
                else begin pu = sa / sb; r = pu[31:0]; end
            end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == MIN && b == '1) r = '0;
                else begin pu = sa % sb; r = pu[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == MIN && b == '1));
    endfunction

    // Single compare process: ready_o, valid_o timing and result_o against the scoreboard.
    always @(negedge clk) begin
        if (mon_en && !rst_i) begin
            chk("ready", {31'b0, ready_o}, {31'b0, (cyc > busy_until)});
            if (valid_o) begin
                if (exp_res_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_valid: got valid_o=1 result %h want no valid (cyc %0d)", result_o, cyc);
                end else begin
                    chk("result", result_o, exp_res_q[0]);
                    chk("latency", 32'(cyc), 32'(exp_cyc_q[0]));
                    last_res = exp_res_q.pop_front();
                    void'(exp_cyc_q.pop_front());
                end
            end else begin
                chk("held", result_o, last_res);
                if (exp_cyc_q.size() != 0 && cyc >= exp_cyc_q[0]) begin
                    total++;
                    bad++;
                    $display("FAIL missing_valid: got none want valid_o in cyc %0d", exp_cyc_q[0]);
                    void'(exp_res_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_o) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got ready_o=0 want 1 within 100 cycles");
        end
    endtask

    // flush_at = 0: run to completion; otherwise flush during that cycle after accept.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit lit, input logic [31:0] lit_exp, input int flush_at);
        int          acc0, lat;
        logic [31:0] e;
        wait_ready();
        e   = lit ? lit_exp : ref_res(f, a, b);
        lat = is_fast(f, a, b) ? 1 : 33;
        funct3_i = f; a_i = a; b_i = b; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; a_i = $urandom(); b_i = $urandom(); funct3_i = 3'($urandom_range(0, 7));
        acc0 = cyc - 1;
        busy_until = acc0 + lat;
        if (flush_at == 0) begin
            exp_res_q.push_back(e);
            exp_cyc_q.push_back(acc0 + lat);
            repeat (lat) @(posedge clk);
            #1;
        end else begin
            repeat (flush_at - 1) @(posedge clk);
            #1;
            flush_i = 1'b1;
            busy_until = acc0 + flush_at;
            @(posedge clk); #1;
            flush_i = 1'b0;
            chk("ready_after_flush", {31'b0, ready_o}, 32'd1);
        end
    endtask

    task automatic op4(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit lit, input logic [31:0] lit_exp);
        int          n;
        logic [31:0] e;
        e = lit ? lit_exp : ref_res(f, a, b);
        f4 = f; a4 = a; b4 = b; v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        n  = 1;
        while (!vo4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!vo4) begin
            total++;
            bad++;
            $display("FAIL bpc4_timeout: got no valid_o want valid within 40 cycles");
        end else begin
            chk("bpc4_latency", 32'(n), is_fast(f, a, b) ? 32'd1 : 32'd9);
            chk("bpc4_result", r4, e);
        end
        @(posedge clk); #1;
        chk("bpc4_ready", {31'b0, rdy4}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running want finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] ra, rb;

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; funct3_i = '0; a_i = '0; b_i = '0;
        v4 = 1'b0; f4 = '0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        @(posedge clk); #1;
        rst_i  = 1'b0;
        mon_en = 1'b1;

        do_op(3'd0, 32'd7,        32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 0);
        do_op(3'd1, MIN,          MIN,           1, 32'h4000_0000, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2,        1, 32'hFFFF_FFFD, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2,        1, 32'hFFFF_FFFF, 0);
        do_op(3'd5, 32'd100,      32'd7,         1, 32'd14,        0);
        do_op(3'd7, 32'd100,      32'd7,         1, 32'd2,         0);
        do_op(3'd4, 32'd5,        32'd0,         1, 32'hFFFF_FFFF, 0);
        do_op(3'd7, 32'd5,        32'd0,         1, 32'd5,         0);
        do_op(3'd4, MIN,          32'hFFFF_FFFF, 1, MIN,           0);
        do_op(3'd6, MIN,          32'hFFFF_FFFF, 1, 32'd0,         0);

        do_op(3'd0, 32'h1234_5678, 32'h9abc_def0, 0, 32'd0, 10);
        do_op(3'd5, 32'd9,         32'd3,         1, 32'd3, 0);
        do_op(3'd4, 32'd5,         32'd0,         0, 32'd0, 1);

        // valid_i together with flush_i in IDLE must not start anything.
        funct3_i = 3'd0; a_i = 32'd3; b_i = 32'd4; valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        chk("idle_flush_blocks", {31'b0, ready_o}, 32'd1);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = MIN;
                1:       ra = 32'($urandom_range(0, 20));
                2:       ra = '1;
                default: ra = $urandom();
            endcase
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = '1;
                2:       rb = 32'($urandom_range(1, 9));
                default: rb = $urandom();
            endcase
            do_op(3'($urandom_range(0, 7)), ra, rb, 0, 32'd0, 0);
        end

        // Asynchronous reset between clock edges while in CALC.
        wait_ready();
        funct3_i = 3'd0; a_i = 32'd11; b_i = 32'd13; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        busy_until = cyc - 1 + 33;
        repeat (5) @(posedge clk);
        #3;
        rst_i = 1'b1;
        exp_res_q.delete();
        exp_cyc_q.delete();
        busy_until = -1;
        last_res = '0;
        #1;
        chk("arst_ready", {31'b0, ready_o}, 32'd1);
        chk("arst_valid", {31'b0, valid_o}, 32'd0);
        chk("arst_result", result_o, 32'd0);
        rst_i = 1'b0;
        @(posedge clk); #1;
        do_op(3'd5, 32'd9, 32'd3, 1, 32'd3, 0);

        op4(3'd0, 32'd6, 32'd7, 1, 32'd42);
        for (int i = 0; i < 20; i++) begin
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom();
            op4(3'($urandom_range(0, 7)), $urandom(), rb, 0, 32'd0);
        end

        repeat (3) @(posedge clk);
        mon_en = 1'b0;
        if (exp_res_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: got %0d pending results want 0", exp_res_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit; sits beside the single-cycle ALU in the execute stage.
- Takes operands plus funct3 from the M-extension decode, stalls the pipeline through a ready/valid handshake, and returns one XLEN result.
- Generalised in width (XLEN) and radix (bits retired per cycle).
- RISC-V corner cases (divide by zero, signed overflow) take a one-cycle fast path.

Parameters:
- XLEN, 32, operand/result width; even, >= 8.
- BITS_PER_CYCLE, 1, multiplier/quotient bits retired per iteration; allowed 1, 2, 4; must divide XLEN.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  operation request.
- ready_o  output  1  unit idle and able to accept.
- funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a_i  input  XLEN  rs1 operand; signed for MULH/MULHSU/DIV/REM.
- b_i  input  XLEN  rs2 operand; signed for MULH/DIV/REM, unsigned for MULHSU.
- flush_i  input  1  abort any in-flight operation.
- valid_o  output  1  one-cycle pulse; result_o is valid.
- result_o  output  XLEN  result, held until the next valid_o.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; ready_o = 1; valid_o = 0; result_o = 0; all internal registers cleared.
  - Asserting reset mid-operation discards the operation, and valid_o never fires for it.
- States: IDLE, CALC, DONE.
- ready_o = (state == IDLE). valid_i is ignored outside IDLE.
- Accept: a rising edge with IDLE & valid_i & !flush_i captures funct3_i, a_i and b_i.
  - Fast case (DIV/DIVU/REM/REMU with b == 0, or DIV/REM with a == most-negative and b == all-ones): go directly to DONE with the result preset.
  - Otherwise: go to CALC with the counter at N = XLEN / BITS_PER_CYCLE.
- CALC:
  - Operands are converted to magnitudes at accept; the result sign is recorded per op.
  - Multiply: shift-add over a 2*XLEN accumulator, BITS_PER_CYCLE multiplier bits per cycle.
  - Divide: restoring division, BITS_PER_CYCLE quotient bits per cycle.
  - Counter decrements each cycle; leave for DONE on the edge where it reaches 0, i.e. after exactly N CALC cycles.
- DONE (1 cycle):
  - valid_o = 1.
  - result_o is selected and sign-corrected: MUL = low XLEN of product; MULH* = high XLEN; DIV* = quotient; REM* = remainder.
  - Next state is IDLE.
- Latency: the accept edge is cycle 0.
  - Normal ops: valid_o high in cycle N+1; ready_o high again in cycle N+2.
  - Fast case: valid_o high in cycle 1.
- Sign rules:
  - Quotient is negative iff operand signs differ.
  - Remainder takes the dividend's sign; a zero remainder stays 0.
  - MULHSU treats only a as signed.
  - All arithmetic is mod 2^XLEN, with no exceptions raised.
- Corner results:
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = a.
  - Signed overflow: DIV = most-negative; REM = 0.
- flush_i:
  - In CALC or DONE, the next state is IDLE; valid_o is forced to 0 that cycle, and result_o keeps its previous value.
  - flush_i in IDLE blocks an accept in the same cycle.
- No back-to-back accept in the DONE cycle, because ready_o is low there.
- No X propagation: unused funct3 encodings cannot occur, since all 8 are defined.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> result_o=0xFFFFFFEB; valid_o exactly in cycle 33 after accept (XLEN=32, BPC=1); ready_o low cycles 1-33.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF (-1), b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. All with latency 33.
- Fast path:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  - Each returns valid_o in cycle 1.
- Abort: flush_i asserted in CALC cycle 10 -> no valid_o; ready_o=1 next cycle; result_o unchanged. A following DIVU 9/3 -> 3.
- Async rst_i pulsed mid-CALC between clock edges -> ready_o=1, valid_o=0, result_o=0 immediately. BPC=4 build: MUL 6×7 -> 42 with valid_o in cycle 9.
